// File: rtl/lns_normalizer_if.sv
// rtl/lns_normalizer_if.sv - handshake bundle between operand producer, normalizer and log stage
// Ports (grouped signals):
//   data_in / data_in_valid / data_in_enable          operand side, valid/enable transfer
//   data_out / exp_out / zero_out / data_out_valid /
//   data_out_enable                                   result side, valid/enable transfer
// Modports: master = producer/consumer environment, slave = normalizer.
interface lns_normalizer_if #(
  parameter int IN_BITS = 16,
  parameter int X_BITS  = 8,
  parameter int E_BITS  = $clog2(IN_BITS)
);
  logic [IN_BITS-1:0] data_in;
  logic               data_in_valid;
  logic               data_in_enable;
  logic [X_BITS-1:0]  data_out;
  logic [E_BITS-1:0]  exp_out;
  logic               zero_out;
  logic               data_out_valid;
  logic               data_out_enable;

  modport master (
    output data_in, data_in_valid, data_out_enable,
    input  data_in_enable, data_out, exp_out, zero_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_enable,
    output data_in_enable, data_out, exp_out, zero_out, data_out_valid
  );
endinterface

// File: rtl/lns_normalizer.sv
// rtl/lns_normalizer.sv - integer-to-LNS front end: leading-one exponent and fraction mantissa
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   lns_normalizer_if.slave: operand in (data_in*), result out (data_out, exp_out,
//         zero_out, data_out_valid/data_out_enable)
module lns_normalizer #(
  parameter int IN_BITS = 16,
  parameter int X_BITS  = 8,
  parameter int E_BITS  = $clog2(IN_BITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  lns_normalizer_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              r_state;
  logic [IN_BITS-1:0]  r_shift;
  logic [E_BITS-1:0]   r_exp_cnt;
  logic [X_BITS-1:0]   r_data_out;
  logic [E_BITS-1:0]   r_exp_out;
  logic                r_zero_out;
  logic                r_data_out_valid;

  logic                w_in_enable;
  logic                w_in_xfer;
  logic                w_out_xfer;

  // Ready is decoded from state and forced low while reset is asserted.
  assign w_in_enable = (r_state == IDLE) && !rst;
  assign w_in_xfer   = bus.data_in_valid && w_in_enable;
  assign w_out_xfer  = (r_state == DONE) && bus.data_out_enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state          <= IDLE;
      r_shift          <= '0;
      r_exp_cnt        <= '0;
      r_data_out       <= '0;
      r_exp_out        <= '0;
      r_zero_out       <= 1'b0;
      r_data_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_data_out_valid <= 1'b0;
          if (w_in_xfer) begin
            r_shift   <= bus.data_in;
            r_exp_cnt <= E_BITS'(IN_BITS - 1);
            if (bus.data_in == '0) begin
              // Zero has no leading one; report it directly with cleared fields.
              r_data_out       <= '0;
              r_exp_out        <= '0;
              r_zero_out       <= 1'b1;
              r_data_out_valid <= 1'b1;
              r_state          <= DONE;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (r_shift[IN_BITS-1]) begin
            // Leading one is now at the MSB; the implied 1 is dropped and
            // fraction bits below X_BITS are truncated.
            r_data_out       <= r_shift[IN_BITS-2 -: X_BITS];
            r_exp_out        <= r_exp_cnt;
            r_zero_out       <= 1'b0;
            r_data_out_valid <= 1'b1;
            r_state          <= DONE;
          end else begin
            // Nonzero operand guarantees the counter stops before wrapping.
            r_shift   <= {r_shift[IN_BITS-2:0], 1'b0};
            r_exp_cnt <= r_exp_cnt - 1'b1;
          end
        end
        DONE: begin
          if (w_out_xfer) begin
            r_data_out_valid <= 1'b0;
            r_state          <= IDLE;
          end
        end
        default: begin
          r_state          <= IDLE;
          r_data_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_in_enable = w_in_enable;
  assign bus.data_out       = r_data_out;
  assign bus.exp_out        = r_exp_out;
  assign bus.zero_out       = r_zero_out;
  assign bus.data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_lns_normalizer.sv
// tb/tb_lns_normalizer.sv - self-checking bench for lns_normalizer
module tb_lns_normalizer;

  logic clk;
  logic rst;

  lns_normalizer_if #(.IN_BITS(16), .X_BITS(8), .E_BITS(4)) bus ();

  lns_normalizer #(.IN_BITS(16), .X_BITS(8), .E_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] frac;
    logic [3:0] e;
    logic       z;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   tests;
  int   fails;

  function automatic exp_t model(input logic [15:0] v);
    exp_t r;
    int   p;
    logic [31:0] w;
    r.frac = 8'h00;
    r.e    = 4'd0;
    r.z    = 1'b1;
    r.lat  = 1;
    if (v != 16'h0000) begin
      p = 0;
      for (int i = 0; i < 16; i++) if (v[i]) p = i;
      w = {16'h0000, v} - (32'd1 << p);
      if (p >= 8) w = w >> (p - 8);
      else        w = w << (8 - p);
      r.frac = w[7:0];
      r.e    = 4'(p);
      r.z    = 1'b0;
      r.lat  = 16 - p;
    end
    return r;
  endfunction

  task automatic start_op(input logic [15:0] v, input string name);
    int n;
    n = 0;
    while (!bus.data_in_enable && n < 50) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (bus.data_in_enable !== 1'b1) begin
      fails++;
      $display("FAIL %s start: data_in_enable=%b required 1", name, bus.data_in_enable);
    end
    bus.data_in       = v;
    bus.data_in_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_in_valid = 1'b0;
    sb.push_back(model(v));
  endtask

  task automatic wait_and_check(input string name);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!bus.data_out_valid && lat < 40);
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s scoreboard: empty, required an entry", name);
      return;
    end
    e = sb.pop_front();
    if (!bus.data_out_valid || lat !== e.lat) begin
      fails++;
      $display("FAIL %s latency: got %0d valid=%b required %0d", name, lat, bus.data_out_valid, e.lat);
    end
    tests++;
    if (bus.data_out !== e.frac) begin
      fails++;
      $display("FAIL %s data_out: got %h required %h", name, bus.data_out, e.frac);
    end
    tests++;
    if (bus.exp_out !== e.e) begin
      fails++;
      $display("FAIL %s exp_out: got %0d required %0d", name, bus.exp_out, e.e);
    end
    tests++;
    if (bus.zero_out !== e.z) begin
      fails++;
      $display("FAIL %s zero_out: got %b required %b", name, bus.zero_out, e.z);
    end
  endtask

  task automatic release_out(input string name);
    bus.data_out_enable = 1'b1;
    @(posedge clk); #1;
    bus.data_out_enable = 1'b0;
    tests++;
    if (bus.data_out_valid !== 1'b0 || bus.data_in_enable !== 1'b1) begin
      fails++;
      $display("FAIL %s release: valid=%b in_enable=%b required 0/1", name,
               bus.data_out_valid, bus.data_in_enable);
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.exp_out !== 4'd0 ||
        bus.zero_out !== 1'b0 || bus.data_in_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h exp=%0d zero=%b en=%b required 0/00/0/0/0",
               bus.data_out_valid, bus.data_out, bus.exp_out, bus.zero_out, bus.data_in_enable);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.data_in_enable !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: data_in_enable=%b required 1", bus.data_in_enable);
    end
  endtask

  task automatic test_single(input logic [15:0] v, input string name);
    start_op(v, name);
    wait_and_check(name);
    release_out(name);
  endtask

  task automatic test_backpressure();
    exp_t e;
    start_op(16'h1234, "bp");
    e = sb[0];
    wait_and_check("bp");
    bus.data_in       = 16'hFFFF;
    bus.data_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if (bus.data_out_valid !== 1'b1 || bus.data_out !== e.frac || bus.exp_out !== e.e ||
          bus.zero_out !== e.z || bus.data_in_enable !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b data=%h exp=%0d zero=%b en=%b required 1/%h/%0d/%b/0",
                 i, bus.data_out_valid, bus.data_out, bus.exp_out, bus.zero_out,
                 bus.data_in_enable, e.frac, e.e, e.z);
      end
    end
    bus.data_in_valid = 1'b0;
    release_out("bp");
    @(posedge clk); #1;
    tests++;
    if (bus.data_out_valid !== 1'b0 || bus.data_in_enable !== 1'b1) begin
      fails++;
      $display("FAIL bp_no_capture: valid=%b en=%b required 0/1", bus.data_out_valid, bus.data_in_enable);
    end
  endtask

  task automatic test_reset_mid_shift();
    start_op(16'h0001, "rst_mid");
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    tests++;
    if (bus.data_out_valid !== 1'b0 || bus.data_out !== 8'h00 || bus.exp_out !== 4'd0 ||
        bus.zero_out !== 1'b0 || bus.data_in_enable !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_async: valid=%b data=%h exp=%0d zero=%b en=%b required 0/00/0/0/0",
               bus.data_out_valid, bus.data_out, bus.exp_out, bus.zero_out, bus.data_in_enable);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    tests++;
    if (bus.data_in_enable !== 1'b1 || bus.data_out_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_release: en=%b valid=%b required 1/0", bus.data_in_enable, bus.data_out_valid);
    end
    test_single(16'h8000, "after_rst_8000");
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    for (int i = 0; i < 6; i++) begin
      v = 16'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
      start_op(v, "b2b");
      wait_and_check("b2b");
      release_out("b2b");
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.data_in = 16'h0000;
    bus.data_in_valid = 1'b0;
    bus.data_out_enable = 1'b0;
    test_reset();
    test_single(16'h00CD, "cd");
    test_single(16'h0001, "one");
    test_single(16'hFFFF, "ffff");
    test_single(16'h0000, "zero");
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
